amba_master_cmd: RTL and testbench

AHB-Lite master bridge sitting directly upstream of the memory slave (amba_slave_mem) and the bus decode/mux. It converts a simple valid/ready command stream (single read or write) into pipelined AHB-Lite SINGLE transfers. The address phase of transfer N+1 overlaps the data phase of transfer N. Each completed transfer returns exactly one response beat carrying read data and error status.

---
 rtl/amba_pkg.sv | 37 +++
 rtl/amba_master_cmd.sv | 86 ++++++++
 tb/tb_amba_master_cmd.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amba_pkg.sv
// Shared AMBA AHB-Lite definitions: bus widths, transfer encodings and the
// master command record.
package amba_pkg;

  localparam int AWIDTH = 32;
  localparam int DWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] SIZE_BYTE     = 3'd0;
  localparam logic [2:0] SIZE_HALF     = 3'd1;
  localparam logic [2:0] SIZE_WORD     = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef struct packed {
    logic              write;
    logic [AWIDTH-1:0] addr;
    logic [2:0]        size;
    logic [DWIDTH-1:0] wdata;
  } cmd_t;

  // Clamp oversize requests to a word and force natural alignment.
  function automatic cmd_t norm_cmd(cmd_t c);
    cmd_t n;
    n = c;
    if (c.size > SIZE_WORD) n.size = SIZE_WORD;
    if (n.size == SIZE_HALF)      n.addr[0]   = 1'b0;
    else if (n.size == SIZE_WORD) n.addr[1:0] = 2'b00;
    return n;
  endfunction

endpackage

// File: rtl/amba_master_cmd.sv
// AHB-Lite master bridge: valid/ready command stream in, pipelined SINGLE
// transfers out, one response beat per completed transfer.
module amba_master_cmd
  import amba_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [AWIDTH-1:0] haddr,
  output logic [2:0]        hsize,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DWIDTH-1:0] hrdata,
  output logic              busy
);

  cmd_t              cmd_raw, cmd_in, ap_cmd;
  logic              ap_valid, dp_valid, dp_write;
  logic [DWIDTH-1:0] dp_wdata;
  logic              load;

  assign cmd_raw   = '{write: cmd_write, addr: cmd_addr, size: cmd_size, wdata: cmd_wdata};
  assign cmd_in    = norm_cmd(cmd_raw);
  assign cmd_ready = ~ap_valid | hready;
  assign load      = cmd_valid & cmd_ready;

  // Address stage: an occupied slot holds through wait states, an empty one
  // may fill at any time (IDLE -> NONSEQ during a wait is legal).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_valid <= 1'b0;
      ap_cmd   <= '0;
    end else begin
      ap_valid <= load | (ap_valid & ~hready);
      if (load) ap_cmd <= cmd_in;
    end
  end

  // Data stage advances only when the current data phase completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (hready) begin
      dp_valid <= ap_valid;
      dp_write <= ap_cmd.write;
      dp_wdata <= ap_cmd.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (dp_valid && hready) begin
      rsp_valid <= 1'b1;
      rsp_err   <= hresp;
      rsp_rdata <= dp_write ? '0 : hrdata;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  assign htrans = ap_valid ? NONSEQ : IDLE;
  assign haddr  = ap_cmd.addr;
  assign hsize  = ap_cmd.size;
  assign hwrite = ap_cmd.write;
  assign hburst = HBURST_SINGLE;
  assign hwdata = dp_wdata;
  assign busy   = ap_valid | dp_valid;

endmodule

// File: tb/tb_amba_master_cmd.sv
// Bench for amba_master_cmd: behavioural AHB memory slave with programmable
// wait states and error injection, shadow memory and response scoreboard.
module tb_amba_master_cmd;
  import amba_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AWIDTH-1:0] cmd_addr = '0;
  logic [2:0]        cmd_size = '0;
  logic [DWIDTH-1:0] cmd_wdata = '0;
  logic              rsp_valid, rsp_err;
  logic [DWIDTH-1:0] rsp_rdata;
  logic [AWIDTH-1:0] haddr;
  logic [2:0]        hsize, hburst;
  logic              hwrite, hready, hresp, busy;
  logic [1:0]        htrans;
  logic [DWIDTH-1:0] hwdata, hrdata;

  always #5 clk = ~clk;

  amba_master_cmd dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .htrans(htrans),
    .hburst(hburst), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata), .busy(busy)
  );

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lane_merge(logic [31:0] old, logic [31:0] wd,
                                             logic [31:0] a, logic [2:0] sz);
    logic [31:0] m;
    if (sz == 3'd0)      m = 32'hFF << (8 * a[1:0]);
    else if (sz == 3'd1) m = 32'hFFFF << (16 * a[1]);
    else                 m = 32'hFFFF_FFFF;
    return (old & ~m) | (wd & m);
  endfunction

  // Memory slave: one data phase in flight, waits/err chosen at address phase.
  int          waits = 0, err_idx = -1, nonseq_n = 0, s_cnt = 0;
  logic        s_act = 1'b0, s_wr = 1'b0, s_err = 1'b0;
  logic [31:0] s_addr = '0;
  logic [2:0]  s_size = '0;
  logic [31:0] mem [256];

  assign hready = !s_act || (s_cnt == 0);
  assign hresp  = s_act && s_err;
  assign hrdata = (s_act && !s_wr && !s_err) ? mem[s_addr[9:2]] : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_act <= 1'b0;
      s_cnt <= 0;
    end else if (hready) begin
      if (s_act && s_wr && !s_err)
        mem[s_addr[9:2]] <= lane_merge(mem[s_addr[9:2]], hwdata, s_addr, s_size);
      if (htrans == NONSEQ) begin
        s_act    <= 1'b1;
        s_addr   <= haddr;
        s_size   <= hsize;
        s_wr     <= hwrite;
        s_err    <= (nonseq_n == err_idx);
        s_cnt    <= (nonseq_n == err_idx) ? 1 : waits;
        nonseq_n <= nonseq_n + 1;
      end else begin
        s_act <= 1'b0;
      end
    end else begin
      s_cnt <= s_cnt - 1;
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int cyc; } obs_t;
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; int cyc; } alog_t;
  obs_t  obs_q[$];
  exp_t  exp_q[$];
  alog_t alog_q[$];
  logic [31:0] smem [256];

  logic [31:0] hw_first = '0;
  logic        hw_seen = 1'b0;
  int          hw_changes = 0;

  always @(negedge clk) begin
    if (rsp_valid) obs_q.push_back('{rsp_rdata, rsp_err, cyc});
    if (hready && htrans == NONSEQ) alog_q.push_back('{haddr, hsize, cyc});
    if (s_act && s_wr) begin
      if (!hw_seen) begin hw_first <= hwdata; hw_seen <= 1'b1; end
      else if (hwdata !== hw_first) hw_changes <= hw_changes + 1;
    end
    if (hready) hw_seen <= 1'b0;
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] d, output int stalls);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    stalls = 0;
    while (!cmd_ready && stalls < 100) begin @(negedge clk); stalls++; end
    if (stalls >= 100) begin
      errors++;
      $display("FAIL cmd_accept timeout got ready=%b want 1", cmd_ready);
    end
    @(posedge clk);
  endtask

  // Drives a command and records its expected response in the scoreboard.
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, input logic e, output int stalls);
    logic [2:0]  sz;
    logic [31:0] aa;
    sz = (s > 3'd2) ? 3'd2 : s;
    aa = a;
    if (sz == 3'd1) aa[0] = 1'b0;
    if (sz == 3'd2) aa[1:0] = 2'b00;
    if (w) begin
      if (!e) smem[aa[9:2]] = lane_merge(smem[aa[9:2]], d, aa, sz);
      exp_q.push_back('{32'h0, e});
    end else begin
      exp_q.push_back('{e ? 32'h0 : smem[aa[9:2]], e});
    end
    send_cmd(w, a, s, d, stalls);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (htrans !== IDLE || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in got htrans=%b busy=%b ready=%b want 00/0/1", htrans, busy, cmd_ready);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (htrans !== IDLE || busy !== 1'b0 || cmd_ready !== 1'b1 || haddr !== 32'h0 ||
        hwdata !== 32'h0 || hburst !== 3'b000 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got htrans=%b busy=%b ready=%b haddr=%h hwdata=%h hburst=%b want 00/0/1/0/0/000",
               htrans, busy, cmd_ready, haddr, hwdata, hburst);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_rsp got %0d pulses want 0", obs_q.size());
    end
  endtask

  task automatic test_write_read();
    int st;
    obs_t o; exp_t e;
    waits = 2; hw_changes = 0;
    do_cmd(1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 1'b0, st);
    do_cmd(1'b0, 32'h010, 3'd2, 32'h0, 1'b0, st);
    idle(); wait_rsp();
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL wr_rd count got %0d want 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL wr_rd rsp got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
    checks++;
    if (hw_changes != 0) begin
      errors++; $display("FAIL hwdata_stable got %0d changes want 0", hw_changes);
    end
    obs_q.delete(); exp_q.delete(); alog_q.delete();
  endtask

  task automatic test_byte_lane();
    int st;
    obs_t o; exp_t e;
    waits = 2;
    do_cmd(1'b1, 32'h013, 3'd0, 32'hAA00_0000, 1'b0, st);
    do_cmd(1'b0, 32'h010, 3'd2, 32'h0, 1'b0, st);
    idle(); wait_rsp();
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL byte count got %0d want 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL byte rsp got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
    checks++;
    if (alog_q.size() < 1 || alog_q[0].addr !== 32'h013 || alog_q[0].size !== 3'd0) begin
      errors++; $display("FAIL byte haddr got %h want 00000013", (alog_q.size() > 0) ? alog_q[0].addr : 32'hx);
    end
    obs_q.delete(); exp_q.delete(); alog_q.delete();
  endtask

  task automatic test_align();
    int st;
    obs_t o; exp_t e;
    waits = 0;
    do_cmd(1'b1, 32'h004, 3'd2, 32'h0000_5678, 1'b0, st);
    do_cmd(1'b1, 32'h007, 3'd1, 32'h1234_0000, 1'b0, st);
    do_cmd(1'b0, 32'h007, 3'd7, 32'h0, 1'b0, st);
    idle(); wait_rsp();
    checks++;
    if (alog_q.size() != 3 || alog_q[1].addr !== 32'h006 || alog_q[1].size !== 3'd1) begin
      errors++; $display("FAIL half_align got haddr=%h want 00000006", (alog_q.size() > 1) ? alog_q[1].addr : 32'hx);
    end
    checks++;
    if (alog_q.size() != 3 || alog_q[2].addr !== 32'h004 || alog_q[2].size !== 3'd2) begin
      errors++; $display("FAIL size_clamp got haddr=%h hsize=%b want 00000004/010",
                         (alog_q.size() > 2) ? alog_q[2].addr : 32'hx, (alog_q.size() > 2) ? alog_q[2].size : 3'bx);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL align rsp got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_q.delete(); exp_q.delete(); alog_q.delete();
  endtask

  task automatic test_back_to_back();
    int st, stalls = 0, prev = 0, first_a = 0;
    obs_t o; exp_t e;
    waits = 0;
    for (int i = 0; i < 4; i++) do_cmd(1'b1, 32'h020 + 4*i, 3'd2, 32'hC0DE_0000 + i, 1'b0, st);
    idle(); wait_rsp();
    obs_q.delete(); exp_q.delete(); alog_q.delete();
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 32'h020 + 4*i, 3'd2, 32'h0, 1'b0, st);
      stalls += st;
    end
    idle(); wait_rsp();
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL b2b_ready got %0d stalls want 0", stalls);
    end
    checks++;
    if (alog_q.size() != 4 || alog_q[3].cyc != alog_q[0].cyc + 3) begin
      errors++; $display("FAIL b2b_nonseq got %0d beats want 4 consecutive", alog_q.size());
    end
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL b2b_count got %0d want 4", obs_q.size());
    end
    if (alog_q.size() > 0) first_a = alog_q[0].cyc;
    for (int i = 0; i < 4 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL b2b rsp%0d got %h/%b want %h/%b", i, o.rdata, o.err, e.rdata, e.err);
      end
      checks++;
      if ((i == 0 && o.cyc != first_a + 2) || (i > 0 && o.cyc != prev + 1)) begin
        errors++; $display("FAIL b2b timing rsp%0d got cyc %0d want %0d", i, o.cyc, (i == 0) ? first_a + 2 : prev + 1);
      end
      prev = o.cyc;
    end
    obs_q.delete(); exp_q.delete(); alog_q.delete();
  endtask

  task automatic test_error();
    int st;
    obs_t o; exp_t e;
    waits = 0;
    err_idx = nonseq_n + 1;
    do_cmd(1'b0, 32'h020, 3'd2, 32'h0, 1'b0, st);
    do_cmd(1'b0, 32'h024, 3'd2, 32'h0, 1'b1, st);
    do_cmd(1'b0, 32'h028, 3'd2, 32'h0, 1'b0, st);
    idle(); wait_rsp();
    err_idx = -1;
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL err count got %0d want 3", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL err rsp got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_q.delete(); exp_q.delete(); alog_q.delete();
  endtask

  task automatic test_reset_mid();
    int st, n = 0;
    waits = 4;
    send_cmd(1'b1, 32'h030, 3'd2, 32'h5555_AAAA, st);
    idle();
    while (!(s_act && !hready) && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid busy_before got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (htrans !== IDLE || busy !== 1'b0 || cmd_ready !== 1'b1 || hwdata !== 32'h0 ||
        haddr !== 32'h0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid outputs got htrans=%b busy=%b ready=%b hwdata=%h haddr=%h want 00/0/1/0/0",
               htrans, busy, cmd_ready, hwdata, haddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL rst_mid rsp got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete(); exp_q.delete(); alog_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) smem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_byte_lane();
    test_align();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

endmodule
